// File: rtl/parking_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// parking_access_ctrl_pkg
// Shared definitions for the parking-lot entry controller.
//   parkState_e  : FSM state encoding, also exported on the estado debug port
//   attemptWidth : width of the wrong-PIN attempt counter for a given limit
// -----------------------------------------------------------------------------
package parking_access_ctrl_pkg;

    // The numeric values are visible to software through the estado port,
    // so they are pinned explicitly rather than left to the tool.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_PIN = 3'd1,
        ST_OPEN     = 3'd2,
        ST_BLOCK    = 3'd3
    } parkState_e;

    // The attempt counter must be able to hold the value maxTries itself.
    // A limit of 1 would give $clog2(2) = 1, which is already enough.
    function automatic int attemptWidth(input int maxTries);
        return (maxTries < 1) ? 1 : $clog2(maxTries + 1);
    endfunction

endpackage

// File: rtl/parking_access_ctrl_gate_timer.sv
// -----------------------------------------------------------------------------
// GateTimer
// Counts how long the gate has been open without a vehicle starting to cross.
// The count restarts from zero while clear_i is high. It advances only while
// enable_i is high, so the owner can freeze it once a vehicle is on the line.
// expire_o is a single-cycle pulse in the cycle where the count has reached
// TIMEOUT_CYC-1 and the timer is still enabled.
//
// Ports
//   clock     in  1  system clock, rising edge
//   reset     in  1  synchronous, active-high
//   clear_i   in  1  hold the count at zero
//   enable_i  in  1  advance the count this cycle
//   expire_o  out 1  timeout reached this cycle
// -----------------------------------------------------------------------------
module GateTimer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] count_q;
    logic [TW-1:0] count_d;

    // Next count: clear wins over counting. The counter stops at LAST, so it
    // never wraps even if the owner does not react to the expiry in time.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != LAST)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i & ~clear_i & (count_q == LAST);

endmodule

// File: rtl/parking_access_ctrl.sv
// -----------------------------------------------------------------------------
// parking_access_ctrl
// Parking-lot entry controller. It detects a vehicle arriving at the gate,
// checks PIN entries presented with a one-cycle strobe, opens the gate and
// counts admitted vehicles. It also raises two alarms:
//   - a wrong-PIN alarm after MAX_TRIES consecutive bad entries;
//   - a blocking alarm when a vehicle crosses a closed gate or a second vehicle
//     tailgates the one just admitted.
// All outputs are registered and change one cycle after the input event.
//
// Ports
//   clock                    in  1        system clock, rising edge
//   reset                    in  1        synchronous, active-high
//   sensor_llegada_vehiculo  in  1        vehicle present at the gate
//   sensor_ingreso_vehiculo  in  1        vehicle on the gate line
//   clave                    in  PIN_W    entered PIN, valid with clave_valid
//   clave_valid              in  1        one-cycle strobe for a new PIN entry
//   senal_compuerta          out 1        1 = gate open
//   senal_alarma_pin         out 1        wrong-PIN alarm
//   senal_alarma_bloqueo     out 1        blocking / tailgate alarm
//   intentos                 out IW       consecutive wrong PINs, saturating
//   cuenta_vehiculos         out CNT_W    admitted vehicles, wrapping
//   estado                   out 3        current FSM state (debug)
// -----------------------------------------------------------------------------
module parking_access_ctrl
    import parking_access_ctrl_pkg::*;
#(
    parameter int               PIN_W       = 16,
    parameter logic [PIN_W-1:0] PIN_VALUE   = 16'h3257,
    parameter int               MAX_TRIES   = 3,
    parameter int               TIMEOUT_CYC = 1000,
    parameter int               CNT_W       = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               sensor_llegada_vehiculo,
    input  logic                               sensor_ingreso_vehiculo,
    input  logic [PIN_W-1:0]                   clave,
    input  logic                               clave_valid,
    output logic                               senal_compuerta,
    output logic                               senal_alarma_pin,
    output logic                               senal_alarma_bloqueo,
    output logic [attemptWidth(MAX_TRIES)-1:0] intentos,
    output logic [CNT_W-1:0]                   cuenta_vehiculos,
    output logic [2:0]                         estado
);

    localparam int IW = attemptWidth(MAX_TRIES);
    localparam logic [IW-1:0] TRIES_MAX = IW'(MAX_TRIES);

    parkState_e      state_q;
    logic            ingresoPrev_q;
    logic            ingresoSeen_q;
    logic            gate_q;
    logic            alarmPin_q;
    logic            alarmBlock_q;
    logic [IW-1:0]   tries_q;
    logic [IW-1:0]   tries_d;
    logic [CNT_W-1:0] vehicles_q;

    logic pinOk;
    logic pinWrong;
    logic ingresoFall;
    logic timerClear;
    logic timerEnable;
    logic timerExpire;

    assign pinOk       = clave_valid & (clave == PIN_VALUE);
    assign pinWrong    = clave_valid & (clave != PIN_VALUE);
    assign ingresoFall = ingresoPrev_q & ~sensor_ingreso_vehiculo;

    // The timer only runs while the gate is open. It freezes as soon as the
    // crossing sensor goes high, including in the cycle where it first rises,
    // so a vehicle that is on the line can never be timed out.
    assign timerClear  = (state_q != ST_OPEN);
    assign timerEnable = (state_q == ST_OPEN) & ~ingresoSeen_q & ~sensor_ingreso_vehiculo;

    GateTimer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gateTimer (
        .clock    (clock),
        .reset    (reset),
        .clear_i  (timerClear),
        .enable_i (timerEnable),
        .expire_o (timerExpire)
    );

    // Saturating increment of the wrong-PIN counter. Once the limit is
    // reached, further wrong entries leave the count at the limit.
    always_comb begin
        tries_d = tries_q;
        if (tries_q != TRIES_MAX) begin
            tries_d = tries_q + 1'b1;
        end
    end

    // Main controller: state, edge register, attempt and vehicle counters and
    // all registered outputs are updated here together, so every output
    // reflects the decision made on the same clock edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            ingresoPrev_q <= 1'b0;
            ingresoSeen_q <= 1'b0;
            gate_q        <= 1'b0;
            alarmPin_q    <= 1'b0;
            alarmBlock_q  <= 1'b0;
            tries_q       <= '0;
            vehicles_q    <= '0;
        end else begin
            ingresoPrev_q <= sensor_ingreso_vehiculo;

            case (state_q)
                ST_IDLE: begin
                    gate_q        <= 1'b0;
                    ingresoSeen_q <= 1'b0;
                    if (sensor_llegada_vehiculo && sensor_ingreso_vehiculo) begin
                        state_q      <= ST_BLOCK;
                        alarmBlock_q <= 1'b1;
                    end else if (sensor_llegada_vehiculo) begin
                        state_q <= ST_WAIT_PIN;
                    end
                end

                // Sensor events outrank a PIN strobe in the same cycle. A driver
                // leaving does not clear the attempt count or the PIN alarm, so
                // the alarm cannot be reset by simply reversing and returning.
                ST_WAIT_PIN: begin
                    gate_q <= 1'b0;
                    if (sensor_ingreso_vehiculo) begin
                        state_q      <= ST_BLOCK;
                        alarmBlock_q <= 1'b1;
                    end else if (pinOk) begin
                        state_q       <= ST_OPEN;
                        gate_q        <= 1'b1;
                        tries_q       <= '0;
                        alarmPin_q    <= 1'b0;
                        ingresoSeen_q <= 1'b0;
                    end else if (pinWrong) begin
                        tries_q <= tries_d;
                        if (tries_d == TRIES_MAX) begin
                            alarmPin_q <= 1'b1;
                        end
                    end else if (!sensor_llegada_vehiculo) begin
                        state_q <= ST_IDLE;
                    end
                end

                // A vehicle counts as admitted when its crossing finishes
                // (falling edge of the line sensor). If another vehicle is
                // already waiting at that moment it is treated as tailgating.
                // PIN strobes are ignored while the gate is open.
                ST_OPEN: begin
                    if (sensor_ingreso_vehiculo) begin
                        ingresoSeen_q <= 1'b1;
                    end
                    if (ingresoFall) begin
                        vehicles_q <= vehicles_q + 1'b1;
                        gate_q     <= 1'b0;
                        if (sensor_llegada_vehiculo) begin
                            state_q      <= ST_BLOCK;
                            alarmBlock_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else if (timerExpire) begin
                        gate_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end

                // Only the correct PIN releases the block; wrong entries here
                // do not touch the attempt counter.
                ST_BLOCK: begin
                    gate_q       <= 1'b0;
                    alarmBlock_q <= 1'b1;
                    if (pinOk) begin
                        state_q      <= ST_IDLE;
                        alarmBlock_q <= 1'b0;
                        alarmPin_q   <= 1'b0;
                        tries_q      <= '0;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    gate_q  <= 1'b0;
                end
            endcase
        end
    end

    assign senal_compuerta      = gate_q;
    assign senal_alarma_pin     = alarmPin_q;
    assign senal_alarma_bloqueo = alarmBlock_q;
    assign intentos             = tries_q;
    assign cuenta_vehiculos     = vehicles_q;
    assign estado               = state_q;

endmodule

// File: tb/tb_parking_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_parking_access_ctrl
// Directed bench for the parking-lot entry controller. The DUT uses a short
// gate timeout (8 cycles) and a 2-bit vehicle counter so that timeout and
// counter wrap are reachable in a few cycles. Inputs change 1 ns after each
// rising edge; outputs are sampled at that same point, after the edge.
// -----------------------------------------------------------------------------
module tb_parking_access_ctrl;

    localparam logic [15:0] GOOD_PIN = 16'h3257;

    logic        clock;
    logic        reset;
    logic        llegada;
    logic        ingreso;
    logic [15:0] clave;
    logic        claveValid;
    logic        compuerta;
    logic        alarmaPin;
    logic        alarmaBloqueo;
    logic [1:0]  intentos;
    logic [1:0]  cuenta;
    logic [2:0]  estado;

    int checks = 0;
    int errors = 0;

    parking_access_ctrl #(
        .PIN_W       (16),
        .PIN_VALUE   (GOOD_PIN),
        .MAX_TRIES   (3),
        .TIMEOUT_CYC (8),
        .CNT_W       (2)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .sensor_llegada_vehiculo (llegada),
        .sensor_ingreso_vehiculo (ingreso),
        .clave                   (clave),
        .clave_valid             (claveValid),
        .senal_compuerta         (compuerta),
        .senal_alarma_pin        (alarmaPin),
        .senal_alarma_bloqueo    (alarmaBloqueo),
        .intentos                (intentos),
        .cuenta_vehiculos        (cuenta),
        .estado                  (estado)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one cycle of inputs, let the DUT take one edge, then settle.
    task automatic applyStimulus(input logic lleg, input logic ing,
                                 input logic valid, input logic [15:0] pin);
        llegada    = lleg;
        ingreso    = ing;
        claveValid = valid;
        clave      = pin;
        @(posedge clock);
        #1;
    endtask

    task automatic checkValue(input string tag, input string field,
                              input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s.%s got %0h expected %0h", tag, field, got, exp);
        end
    endtask

    // Compare every output against the hand-computed expectation.
    task automatic checkOutput(input string tag, input logic gate, input logic alPin,
                               input logic alBlk, input logic [1:0] tries,
                               input logic [1:0] cnt, input logic [2:0] st);
        checkValue(tag, "compuerta", 8'(compuerta),    8'(gate));
        checkValue(tag, "alarmaPin", 8'(alarmaPin),    8'(alPin));
        checkValue(tag, "alarmaBlq", 8'(alarmaBloqueo), 8'(alBlk));
        checkValue(tag, "intentos",  8'(intentos),     8'(tries));
        checkValue(tag, "cuenta",    8'(cuenta),       8'(cnt));
        checkValue(tag, "estado",    8'(estado),       8'(st));
    endtask

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        reset = 1'b0;
        checkOutput("reset", 0, 0, 0, 2'd0, 2'd0, 3'd0);

        // T1: correct PIN, vehicle crosses, driver gone -> count 1, IDLE.
        applyStimulus(1, 0, 0, 16'h0000);
        checkOutput("t1_arrive", 0, 0, 0, 2'd0, 2'd0, 3'd1);
        applyStimulus(1, 0, 1, GOOD_PIN);
        checkOutput("t1_open", 1, 0, 0, 2'd0, 2'd0, 3'd2);
        applyStimulus(0, 1, 0, 16'h0000);
        checkOutput("t1_cross", 1, 0, 0, 2'd0, 2'd0, 3'd2);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t1_done", 0, 0, 0, 2'd0, 2'd1, 3'd0);

        // T2: two wrong PINs, then correct.
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, 16'h7523);
        checkOutput("t2_wrong1", 0, 0, 0, 2'd1, 2'd1, 3'd1);
        applyStimulus(1, 0, 1, 16'h4368);
        checkOutput("t2_wrong2", 0, 0, 0, 2'd2, 2'd1, 3'd1);
        applyStimulus(1, 0, 1, GOOD_PIN);
        checkOutput("t2_open", 1, 0, 0, 2'd0, 2'd1, 3'd2);
        applyStimulus(0, 1, 0, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t2_done", 0, 0, 0, 2'd0, 2'd2, 3'd0);

        // T3: three wrong raise the alarm, fourth saturates, correct clears.
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, 16'h1111);
        applyStimulus(1, 0, 1, 16'h2222);
        checkOutput("t3_wrong2", 0, 0, 0, 2'd2, 2'd2, 3'd1);
        applyStimulus(1, 0, 1, 16'h3333);
        checkOutput("t3_wrong3", 0, 1, 0, 2'd3, 2'd2, 3'd1);
        applyStimulus(1, 0, 1, 16'h4444);
        checkOutput("t3_wrong4", 0, 1, 0, 2'd3, 2'd2, 3'd1);
        applyStimulus(1, 0, 1, GOOD_PIN);
        checkOutput("t3_open", 1, 0, 0, 2'd0, 2'd2, 3'd2);
        applyStimulus(0, 1, 0, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t3_done", 0, 0, 0, 2'd0, 2'd3, 3'd0);

        // T4: arrival and crossing together -> block; wrong PIN keeps it.
        applyStimulus(1, 1, 0, 16'h0000);
        checkOutput("t4_block", 0, 0, 1, 2'd0, 2'd3, 3'd3);
        applyStimulus(1, 0, 1, 16'h5479);
        checkOutput("t4_wrong", 0, 0, 1, 2'd0, 2'd3, 3'd3);
        applyStimulus(0, 0, 1, GOOD_PIN);
        checkOutput("t4_clear", 0, 0, 0, 2'd0, 2'd3, 3'd0);
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, GOOD_PIN);
        checkOutput("t4_open", 1, 0, 0, 2'd0, 2'd3, 3'd2);
        applyStimulus(0, 1, 0, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("t4_wrap", 0, 0, 0, 2'd0, 2'd0, 3'd0);

        // T5: gate times out exactly 8 cycles after opening, no count.
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, GOOD_PIN);
        checkOutput("t5_open", 1, 0, 0, 2'd0, 2'd0, 3'd2);
        applyStimulus(1, 0, 1, 16'h9999);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 0, 0, 16'h0000);
        end
        checkOutput("t5_cycle7", 1, 0, 0, 2'd0, 2'd0, 3'd2);
        applyStimulus(1, 0, 0, 16'h0000);
        checkOutput("t5_timeout", 0, 0, 0, 2'd0, 2'd0, 3'd0);

        // T5b: long crossing freezes the timer; tailgate on falling edge.
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, GOOD_PIN);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 1, 0, 16'h0000);
        end
        checkOutput("t5_frozen", 1, 0, 0, 2'd0, 2'd0, 3'd2);
        applyStimulus(1, 0, 0, 16'h0000);
        checkOutput("t5_tailgate", 0, 0, 1, 2'd0, 2'd1, 3'd3);
        applyStimulus(0, 0, 1, GOOD_PIN);
        checkOutput("t5_clear", 0, 0, 0, 2'd0, 2'd1, 3'd0);

        // Attempts survive the driver leaving; crossing beats a PIN strobe.
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, 16'hAAAA);
        applyStimulus(0, 0, 0, 16'h0000);
        checkOutput("keep_tries", 0, 0, 0, 2'd1, 2'd1, 3'd0);
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 1, 1, GOOD_PIN);
        checkOutput("sensor_wins", 0, 0, 1, 2'd1, 2'd1, 3'd3);
        applyStimulus(0, 0, 1, GOOD_PIN);
        checkOutput("block_clear", 0, 0, 0, 2'd0, 2'd1, 3'd0);

        // T6: reset with the gate open, then four passes wrap the counter.
        applyStimulus(1, 0, 0, 16'h0000);
        applyStimulus(1, 0, 1, GOOD_PIN);
        checkOutput("t6_open", 1, 0, 0, 2'd0, 2'd1, 3'd2);
        reset = 1'b1;
        applyStimulus(0, 0, 0, 16'h0000);
        reset = 1'b0;
        checkOutput("t6_reset", 0, 0, 0, 2'd0, 2'd0, 3'd0);
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 0, 0, 16'h0000);
            applyStimulus(1, 0, 1, GOOD_PIN);
            applyStimulus(0, 1, 0, 16'h0000);
            applyStimulus(0, 0, 0, 16'h0000);
            checkOutput("t6_pass", 0, 0, 0, 2'd0, 2'(i), 3'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
